// File: rtl/bus_dma_initiator.sv
// bus_dma_initiator: word-copy DMA master on the req/gnt/rvalid bus.
// Alternates single reads and writes, one transaction in flight.
module bus_dma_initiator #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic             data_req,
  output logic             data_we,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_gnt,
  input  logic             data_rvalid,
  input  logic [31:0]      data_rdata,
  input  logic             data_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_buf;
  logic [31:0]      r_eaddr;
  logic [31:0]      w_src;
  logic [31:0]      w_dst;
  logic [31:0]      w_buf;
  logic [31:0]      w_eaddr;
  logic [31:0]      w_cur;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer;
  logic             w_rd;
  logic             w_wr;
  logic             w_tmo;

  assign w_rd  = (r_state == S_RD_REQ) ||
                 (r_state == S_RD_WAIT);
  assign w_wr  = (r_state == S_WR_REQ) ||
                 (r_state == S_WR_WAIT);
  assign w_cur = w_rd ? r_src :
                 (w_wr ? r_dst : 32'h0);
  assign w_tmo = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_nxt   = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_cnt   = r_cnt;
    w_buf   = r_buf;
    w_eaddr = r_eaddr;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_src   = cmd_src & ~32'h3;
          w_dst   = cmd_dst & ~32'h3;
          w_cnt   = cmd_len;
          w_eaddr = 32'h0;
          w_nxt   = (cmd_len == '0) ? S_DONE
                                    : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (data_gnt) begin
          w_nxt = S_RD_WAIT;
        end else if (w_tmo) begin
          w_nxt   = S_ERR;
          w_eaddr = r_src;
        end
      end
      S_RD_WAIT: begin
        if (data_rvalid) begin
          if (data_err) begin
            w_nxt   = S_ERR;
            w_eaddr = r_src;
          end else begin
            w_buf = data_rdata;
            w_nxt = S_WR_REQ;
          end
        end else if (w_tmo) begin
          w_nxt   = S_ERR;
          w_eaddr = r_src;
        end
      end
      S_WR_REQ: begin
        if (data_gnt) begin
          w_nxt = S_WR_WAIT;
        end else if (w_tmo) begin
          w_nxt   = S_ERR;
          w_eaddr = r_dst;
        end
      end
      S_WR_WAIT: begin
        if (data_rvalid) begin
          if (data_err) begin
            w_nxt   = S_ERR;
            w_eaddr = r_dst;
          end else begin
            w_cnt = r_cnt - LEN_W'(1);
            w_src = r_src + 32'd4;
            w_dst = r_dst + 32'd4;
            w_nxt = (r_cnt == LEN_W'(1)) ? S_DONE
                                         : S_RD_REQ;
          end
        end else if (w_tmo) begin
          w_nxt   = S_ERR;
          w_eaddr = r_dst;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // timer restarts on every state change
  always_comb begin
    w_timer = '0;
    if ((w_rd || w_wr) && (w_nxt == r_state))
      w_timer = r_timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_cnt   <= '0;
      r_buf   <= 32'h0;
      r_eaddr <= 32'h0;
      r_timer <= '0;
    end else begin
      r_state <= w_nxt;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_cnt   <= w_cnt;
      r_buf   <= w_buf;
      r_eaddr <= w_eaddr;
      r_timer <= w_timer;
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign err_addr   = r_eaddr;
  assign data_req   = (r_state == S_RD_REQ) ||
                      (r_state == S_WR_REQ);
  assign data_we    = (r_state == S_WR_REQ);
  assign data_be    = 4'b1111;
  assign data_addr  = w_cur;
  assign data_wdata = (r_state == S_WR_REQ) ? r_buf
                                            : 32'h0;

endmodule

// File: tb/tb_bus_dma_initiator.sv
// tb_bus_dma_initiator: random bus responder plus copy-level model.
// Memory holes at 0x8000-0x8FFF never grant, forcing timeouts.
module tb_bus_dma_initiator;

  localparam int LEN_W = 16;
  localparam int TMO   = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
  } tx_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_src;
  logic [31:0]      cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      err_addr;
  logic             data_req;
  logic             data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_addr;
  logic [31:0]      data_wdata;
  logic             data_gnt;
  logic             data_rvalid;
  logic [31:0]      data_rdata;
  logic             data_err;

  bus_dma_initiator #(
    .LEN_W  (LEN_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_be    (data_be),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .data_err   (data_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  tx_t obs_q[$];
  tx_t exp_q[$];

  int          inj_idx = -1;
  int          tx_idx  = 0;
  int          gwait   = -1;
  bit          pend    = 0;
  int          pdly    = 0;
  logic [31:0] pdata   = '0;
  bit          perr    = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seed(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit hole(logic [31:0] a);
    return a[31:12] == 20'h00008;
  endfunction

  // responder: grant after 0..3 cycles, answer 1..4 cycles later
  always @(negedge clk) begin
    tx_t t;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = $urandom();
    if (!rst) begin
      pend  = 0;
      gwait = -1;
    end else if (pend) begin
      if (pdly == 0) begin
        data_rvalid = 1'b1;
        data_rdata  = pdata;
        data_err    = perr;
        pend        = 0;
      end else begin
        pdly--;
      end
    end else if (data_req) begin
      if (!hole(data_addr)) begin
        if (gwait < 0) gwait = $urandom_range(0, 3);
        if (gwait == 0) begin
          data_gnt = 1'b1;
          gwait    = -1;
          perr     = (tx_idx == inj_idx);
          if (data_we) begin
            if (!perr) bus_mem[data_addr] = data_wdata;
            pdata = $urandom();
          end else begin
            pdata = bus_mem.exists(data_addr) ?
                    bus_mem[data_addr] : seed(data_addr);
          end
          t.addr = data_addr;
          t.we   = data_we;
          t.be   = data_be;
          t.data = data_wdata;
          obs_q.push_back(t);
          tx_idx++;
          pend = 1;
          pdly = $urandom_range(0, 3);
        end else begin
          gwait--;
        end
      end
    end else begin
      // stray strobes outside a transaction must be ignored
      data_gnt    = 1'($urandom_range(0, 1));
      data_rvalid = 1'($urandom_range(0, 1));
      data_err    = 1'($urandom_range(0, 1));
    end
  end

  // copy-level model: expected transaction list and outcome
  task automatic model(input logic [31:0] src,
                       input logic [31:0] dst,
                       input int len, input int inj,
                       output bit e,
                       output logic [31:0] ea);
    logic [31:0] tmp [logic [31:0]];
    logic [31:0] s, d, a, b, v;
    tx_t t;
    int idx;
    tmp = ref_mem;
    exp_q.delete();
    s   = src & ~32'h3;
    d   = dst & ~32'h3;
    idx = 0;
    e   = 0;
    ea  = '0;
    for (int i = 0; i < len; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      if (hole(a)) begin e = 1; ea = a; break; end
      v = tmp.exists(a) ? tmp[a] : seed(a);
      t = '{addr: a, we: 1'b0, be: 4'hF, data: '0};
      exp_q.push_back(t);
      if (idx == inj) begin e = 1; ea = a; break; end
      idx++;
      if (hole(b)) begin e = 1; ea = b; break; end
      t = '{addr: b, we: 1'b1, be: 4'hF, data: v};
      exp_q.push_back(t);
      if (idx == inj) begin e = 1; ea = b; break; end
      tmp[b] = v;
      idx++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] src,
                         input logic [31:0] dst,
                         input int len, input int inj,
                         input bit hold, input bit rst_wr);
    bit e, seen_req, hit, did_rst;
    logic [31:0] ea;
    int cyc, n;
    model(src, dst, len, inj, e, ea);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    obs_q.delete();
    tx_idx    = 0;
    inj_idx   = inj;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    tick();
    if (hold) begin
      cmd_src = $urandom();
      cmd_dst = $urandom();
      cmd_len = LEN_W'($urandom_range(1, 9));
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 1;
    seen_req = 0;
    hit = 0;
    did_rst = 0;
    while (cyc < 400) begin
      if (rst_wr && data_req && data_we) begin
        rst = 1'b0;
        tick();
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_eaddr", err_addr, 32'd0);
        rst = 1'b1;
        did_rst = 1;
        break;
      end
      if (done || err) begin hit = 1; break; end
      seen_req |= data_req;
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    if (!did_rst) begin
      chk("pulse_seen", 32'(hit), 32'd1);
      chk("done", 32'(done), 32'(!e));
      chk("err", 32'(err), 32'(e));
      chk("busy_end", 32'(busy), 32'd1);
      chk("req_end", 32'(data_req), 32'd0);
      if (e) chk("err_addr", err_addr, ea);
      if (len == 0) begin
        chk("len0_cyc", cyc, 32'd1);
        chk("len0_req", 32'(seen_req), 32'd0);
      end
      chk("tx_cnt", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ?
        obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk("tx_addr", obs_q[k].addr, exp_q[k].addr);
      chk("tx_we", 32'(obs_q[k].we), 32'(exp_q[k].we));
      chk("tx_be", 32'(obs_q[k].be), 32'hF);
      if (exp_q[k].we)
        chk("tx_wdata", obs_q[k].data, exp_q[k].data);
      if (exp_q[k].we && k != inj)
        ref_mem[exp_q[k].addr] = exp_q[k].data;
    end
    if (!did_rst) begin
      tick();
      chk("pulse_len", 32'(done | err), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      if (e) chk("eaddr_hold", err_addr, ea);
    end
  endtask

  initial begin
    logic [31:0] s, d;
    int l, inj;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    repeat (3) tick();
    chk("rst_state_req", 32'(data_req), 32'd0);
    chk("rst_state_we", 32'(data_we), 32'd0);
    chk("rst_state_addr", data_addr, 32'd0);
    chk("rst_state_wdata", data_wdata, 32'd0);
    chk("rst_state_busy", 32'(busy), 32'd0);
    chk("rst_state_pulse", 32'(done | err), 32'd0);
    chk("rst_state_ready", 32'(cmd_ready), 32'd1);
    chk("rst_state_eaddr", err_addr, 32'd0);
    rst = 1'b1;
    tick();

    run_cmd(32'h0000_1000, 32'h0000_1004, 1, -1, 0, 0);
    run_cmd(32'h0000_0000, 32'h0000_0100, 4, -1, 0, 0);
    run_cmd(32'h0000_0040, 32'h0000_0140, 0, -1, 0, 0);
    run_cmd(32'h0000_8000, 32'h0000_0200, 2, -1, 0, 0);
    run_cmd(32'h0000_0300, 32'h0000_8FFC, 2, -1, 0, 0);
    run_cmd(32'h0000_0200, 32'h0000_0020, 3, 3, 0, 0);
    run_cmd(32'h0000_0400, 32'h0000_0500, 2, 0, 0, 0);
    run_cmd(32'hFFFF_FFF8, 32'h0000_0600, 4, -1, 0, 0);
    run_cmd(32'h0000_0703, 32'hFFFF_FFFE, 3, -1, 1, 0);
    run_cmd(32'h0000_0800, 32'h0000_0900, 3, -1, 0, 1);
    run_cmd(32'h0000_0900, 32'h0000_0A00, 3, -1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      s = $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
      d = $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) s = 32'hFFFF_FFF0;
      if ($urandom_range(0, 9) == 0) s = 32'h0000_8000;
      if ($urandom_range(0, 9) == 0) d = 32'h0000_8FF8;
      l   = $urandom_range(0, 6);
      inj = ($urandom_range(0, 3) == 0) ?
            $urandom_range(0, 2 * l) : -1;
      run_cmd(s, d, l, inj,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 11) == 0) && (l > 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
